// File: rtl/regfile_sequencer.sv
// Command sequencer for a small register file: latches a 9-bit command and
// walks it through one or two execute cycles, driving the bus strobes and selects.
module regfile_sequencer (
   input  logic       CLK,
   input  logic       RST_bar,
   input  logic [8:0] CMD,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   output logic       ADDR_ASSERT_bar,
   output logic       ADDR_LOAD_bar,
   output logic       ADDR_INC,
   output logic       MAIN_ASSERT_bar,
   output logic       MAIN_LOAD_bar,
   output logic       LHS_ASSERT_bar,
   output logic       RHS_ASSERT_bar,
   output logic [2:0] ADDR_ASSERT_SEL,
   output logic [2:0] ADDR_LOAD_SEL,
   output logic [2:0] ADDR_INC_SEL,
   output logic [2:0] MAIN_ASSERT_SEL,
   output logic [2:0] MAIN_LOAD_SEL,
   output logic [2:0] LHS_ASSERT_SEL,
   output logic [2:0] RHS_ASSERT_SEL,
   output logic       MEM_READ_bar,
   output logic       ALU_ASSERT_bar,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR
);

   typedef enum logic [1:0] {IDLE = 2'd0, EX1 = 2'd1, EX2 = 2'd2} state_t;

   localparam logic [2:0] OP_MOV   = 3'd0;
   localparam logic [2:0] OP_INC16 = 3'd1;
   localparam logic [2:0] OP_FETCH = 3'd2;
   localparam logic [2:0] OP_ALU   = 3'd3;
   localparam logic [2:0] OP_ACOPY = 3'd4;

   typedef struct packed {
      logic       cmd_ready;
      logic       addr_assert_n;
      logic       addr_load_n;
      logic       addr_inc;
      logic       main_assert_n;
      logic       main_load_n;
      logic       lhs_assert_n;
      logic       rhs_assert_n;
      logic       mem_read_n;
      logic       alu_assert_n;
      logic       busy;
      logic       done;
      logic [2:0] addr_assert_sel;
      logic [2:0] addr_load_sel;
      logic [2:0] addr_inc_sel;
      logic [2:0] main_assert_sel;
      logic [2:0] main_load_sel;
      logic [2:0] lhs_assert_sel;
      logic [2:0] rhs_assert_sel;
   } out_t;

   // Strobe/select pattern for a given state and latched command. Outputs are
   // registered, so this is evaluated on the next-state values.
   function automatic out_t decode(input state_t st, input logic [8:0] c);
      out_t o;
      o = '{cmd_ready: 1'b0, addr_assert_n: 1'b1, addr_load_n: 1'b1, addr_inc: 1'b0,
            main_assert_n: 1'b1, main_load_n: 1'b1, lhs_assert_n: 1'b1, rhs_assert_n: 1'b1,
            mem_read_n: 1'b1, alu_assert_n: 1'b1, busy: 1'b0, done: 1'b0,
            default: 3'd0};
      case (st)
         IDLE: o.cmd_ready = 1'b1;
         EX1: begin
            o.busy      = 1'b1;
            o.done      = 1'b1;
            o.cmd_ready = 1'b1;
            case (c[8:6])
               OP_MOV: begin
                  o.main_assert_n   = 1'b0;
                  o.main_assert_sel = {1'b0, c[3:2]};
                  o.main_load_n     = 1'b0;
                  o.main_load_sel   = {1'b0, c[5:4]};
               end
               OP_INC16: begin
                  o.addr_inc     = 1'b1;
                  o.addr_inc_sel = {1'b0, c[5:4]};
               end
               OP_FETCH: begin
                  o.done            = 1'b0;
                  o.cmd_ready       = 1'b0;
                  o.addr_assert_n   = 1'b0;
                  o.addr_assert_sel = {1'b0, c[3:2]};
                  o.mem_read_n      = 1'b0;
                  o.main_load_n     = 1'b0;
                  o.main_load_sel   = {1'b0, c[5:4]};
               end
               OP_ALU: begin
                  o.lhs_assert_n   = 1'b0;
                  o.lhs_assert_sel = {1'b0, c[3:2]};
                  o.rhs_assert_n   = 1'b0;
                  o.rhs_assert_sel = {1'b0, c[1:0]};
                  o.alu_assert_n   = 1'b0;
                  o.main_load_n    = 1'b0;
                  o.main_load_sel  = {1'b0, c[5:4]};
               end
               OP_ACOPY: begin
                  o.addr_assert_n   = 1'b0;
                  o.addr_assert_sel = {1'b0, c[3:2]};
                  o.addr_load_n     = 1'b0;
                  o.addr_load_sel   = {1'b0, c[5:4]};
               end
               default: o.done = 1'b1;  // illegal opcode: no strobes
            endcase
         end
         EX2: begin
            o.busy         = 1'b1;
            o.done         = 1'b1;
            o.cmd_ready    = 1'b1;
            o.addr_inc     = 1'b1;
            o.addr_inc_sel = {1'b0, c[3:2]};
         end
         default: o.cmd_ready = 1'b1;
      endcase
      return o;
   endfunction

   state_t     state_r, state_s;
   logic [8:0] cmd_r, cmd_s;
   out_t       out_r, out_s;
   logic       err_r;
   logic       accept_s;

   // Next state and next latched command.
   always_comb begin
      accept_s = CMD_VALID & out_r.cmd_ready;
      state_s  = IDLE;
      cmd_s    = cmd_r;
      if (accept_s) begin
         state_s = EX1;
         cmd_s   = CMD;
      end else if ((state_r == EX1) && (cmd_r[8:6] == OP_FETCH)) begin
         state_s = EX2;
      end else begin
         state_s = IDLE;
      end
      out_s = decode(state_s, cmd_s);
   end

   // State, command latch, registered outputs and sticky error flag.
   always_ff @(posedge CLK) begin
      if (!RST_bar) begin
         state_r <= IDLE;
         cmd_r   <= 9'd0;
         out_r   <= decode(IDLE, 9'd0);
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cmd_r   <= cmd_s;
         out_r   <= out_s;
         err_r   <= err_r | ((state_r == EX1) && (cmd_r[8:6] >= 3'd5));
      end
   end

   assign CMD_READY       = out_r.cmd_ready;
   assign ADDR_ASSERT_bar = out_r.addr_assert_n;
   assign ADDR_LOAD_bar   = out_r.addr_load_n;
   assign ADDR_INC        = out_r.addr_inc;
   assign MAIN_ASSERT_bar = out_r.main_assert_n;
   assign MAIN_LOAD_bar   = out_r.main_load_n;
   assign LHS_ASSERT_bar  = out_r.lhs_assert_n;
   assign RHS_ASSERT_bar  = out_r.rhs_assert_n;
   assign ADDR_ASSERT_SEL = out_r.addr_assert_sel;
   assign ADDR_LOAD_SEL   = out_r.addr_load_sel;
   assign ADDR_INC_SEL    = out_r.addr_inc_sel;
   assign MAIN_ASSERT_SEL = out_r.main_assert_sel;
   assign MAIN_LOAD_SEL   = out_r.main_load_sel;
   assign LHS_ASSERT_SEL  = out_r.lhs_assert_sel;
   assign RHS_ASSERT_SEL  = out_r.rhs_assert_sel;
   assign MEM_READ_bar    = out_r.mem_read_n;
   assign ALU_ASSERT_bar  = out_r.alu_assert_n;
   assign BUSY            = out_r.busy;
   assign DONE            = out_r.done;
   assign ERR             = err_r;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: hand-computed expectations per step,
// followed by a random stream checking MAIN-bus exclusivity.
module tb_regfile_sequencer;

   logic       CLK = 1'b0;
   logic       RST_bar;
   logic [8:0] CMD;
   logic       CMD_VALID;
   logic       CMD_READY, ADDR_ASSERT_bar, ADDR_LOAD_bar, ADDR_INC;
   logic       MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar;
   logic [2:0] ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL;
   logic [2:0] MAIN_ASSERT_SEL, MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL;
   logic       MEM_READ_bar, ALU_ASSERT_bar, BUSY, DONE, ERR;

   int n_cmp = 0;
   int n_err = 0;

   regfile_sequencer dut (
      .CLK(CLK), .RST_bar(RST_bar), .CMD(CMD), .CMD_VALID(CMD_VALID),
      .CMD_READY(CMD_READY), .ADDR_ASSERT_bar(ADDR_ASSERT_bar),
      .ADDR_LOAD_bar(ADDR_LOAD_bar), .ADDR_INC(ADDR_INC),
      .MAIN_ASSERT_bar(MAIN_ASSERT_bar), .MAIN_LOAD_bar(MAIN_LOAD_bar),
      .LHS_ASSERT_bar(LHS_ASSERT_bar), .RHS_ASSERT_bar(RHS_ASSERT_bar),
      .ADDR_ASSERT_SEL(ADDR_ASSERT_SEL), .ADDR_LOAD_SEL(ADDR_LOAD_SEL),
      .ADDR_INC_SEL(ADDR_INC_SEL), .MAIN_ASSERT_SEL(MAIN_ASSERT_SEL),
      .MAIN_LOAD_SEL(MAIN_LOAD_SEL), .LHS_ASSERT_SEL(LHS_ASSERT_SEL),
      .RHS_ASSERT_SEL(RHS_ASSERT_SEL), .MEM_READ_bar(MEM_READ_bar),
      .ALU_ASSERT_bar(ALU_ASSERT_bar), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk1({tag, ".busy"}, BUSY, 1'b0);
      chk1({tag, ".done"}, DONE, 1'b0);
      chk1({tag, ".ready"}, CMD_READY, 1'b1);
      chk1({tag, ".addr_inc"}, ADDR_INC, 1'b0);
      chk1({tag, ".bars"}, &{ADDR_ASSERT_bar, ADDR_LOAD_bar, MAIN_ASSERT_bar, MAIN_LOAD_bar,
                             LHS_ASSERT_bar, RHS_ASSERT_bar, MEM_READ_bar, ALU_ASSERT_bar}, 1'b1);
      chk1({tag, ".sels"}, |{ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL, MAIN_ASSERT_SEL,
                             MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL}, 1'b0);
   endtask

   initial begin
      RST_bar = 1'b0; CMD = 9'd0; CMD_VALID = 1'b0;
      tick(); tick();
      check_idle("reset");
      chk1("reset.err", ERR, 1'b0);
      RST_bar = 1'b1;

      // MOV DST=2 SRC=1
      CMD = {3'd0, 2'd2, 2'd1, 2'd0}; CMD_VALID = 1'b1;
      tick(); CMD_VALID = 1'b0;
      chk1("mov.main_assert", MAIN_ASSERT_bar, 1'b0);
      chk3("mov.main_assert_sel", MAIN_ASSERT_SEL, 3'd1);
      chk1("mov.main_load", MAIN_LOAD_bar, 1'b0);
      chk3("mov.main_load_sel", MAIN_LOAD_SEL, 3'd2);
      chk1("mov.done", DONE, 1'b1);
      chk1("mov.busy", BUSY, 1'b1);
      chk1("mov.mem_read", MEM_READ_bar, 1'b1);
      tick();
      check_idle("mov_after");

      // FETCH DST=3 SRC=2, with a MOV held pending through EX1
      CMD = {3'd2, 2'd3, 2'd2, 2'd0}; CMD_VALID = 1'b1;
      tick();
      CMD = {3'd0, 2'd1, 2'd0, 2'd0};
      chk1("fetch1.addr_assert", ADDR_ASSERT_bar, 1'b0);
      chk3("fetch1.addr_assert_sel", ADDR_ASSERT_SEL, 3'd2);
      chk1("fetch1.mem_read", MEM_READ_bar, 1'b0);
      chk1("fetch1.main_load", MAIN_LOAD_bar, 1'b0);
      chk3("fetch1.main_load_sel", MAIN_LOAD_SEL, 3'd3);
      chk1("fetch1.done", DONE, 1'b0);
      chk1("fetch1.ready", CMD_READY, 1'b0);
      tick();
      chk1("fetch2.addr_inc", ADDR_INC, 1'b1);
      chk3("fetch2.addr_inc_sel", ADDR_INC_SEL, 3'd2);
      chk1("fetch2.done", DONE, 1'b1);
      chk1("fetch2.mem_read", MEM_READ_bar, 1'b1);
      chk1("fetch2.main_assert", MAIN_ASSERT_bar, 1'b1);
      tick(); CMD_VALID = 1'b0;
      chk1("pend.main_assert", MAIN_ASSERT_bar, 1'b0);
      chk3("pend.main_assert_sel", MAIN_ASSERT_SEL, 3'd0);
      chk3("pend.main_load_sel", MAIN_LOAD_SEL, 3'd1);
      chk1("pend.addr_inc", ADDR_INC, 1'b0);
      tick();
      check_idle("pend_after");

      // Back-to-back INC16 DST=0, ALU DST=1 SRC=2 SRC2=3, ACOPY DST=SRC=1
      CMD = {3'd1, 2'd0, 2'd0, 2'd0}; CMD_VALID = 1'b1;
      tick();
      CMD = {3'd3, 2'd1, 2'd2, 2'd3};
      chk1("inc.addr_inc", ADDR_INC, 1'b1);
      chk3("inc.addr_inc_sel", ADDR_INC_SEL, 3'd0);
      chk1("inc.done", DONE, 1'b1);
      chk1("inc.ready", CMD_READY, 1'b1);
      tick();
      CMD = {3'd4, 2'd1, 2'd1, 2'd0};
      chk1("alu.busy", BUSY, 1'b1);
      chk1("alu.addr_inc", ADDR_INC, 1'b0);
      chk1("alu.lhs", LHS_ASSERT_bar, 1'b0);
      chk3("alu.lhs_sel", LHS_ASSERT_SEL, 3'd2);
      chk1("alu.rhs", RHS_ASSERT_bar, 1'b0);
      chk3("alu.rhs_sel", RHS_ASSERT_SEL, 3'd3);
      chk1("alu.alu_assert", ALU_ASSERT_bar, 1'b0);
      chk3("alu.main_load_sel", MAIN_LOAD_SEL, 3'd1);
      chk1("alu.main_assert", MAIN_ASSERT_bar, 1'b1);
      chk1("alu.done", DONE, 1'b1);
      tick(); CMD_VALID = 1'b0;
      chk1("acopy.addr_assert", ADDR_ASSERT_bar, 1'b0);
      chk3("acopy.addr_assert_sel", ADDR_ASSERT_SEL, 3'd1);
      chk1("acopy.addr_load", ADDR_LOAD_bar, 1'b0);
      chk3("acopy.addr_load_sel", ADDR_LOAD_SEL, 3'd1);
      chk1("acopy.lhs", LHS_ASSERT_bar, 1'b1);
      chk1("acopy.alu_assert", ALU_ASSERT_bar, 1'b1);
      tick();
      check_idle("acopy_after");

      // Illegal OP=6
      CMD = {3'd6, 2'd3, 2'd3, 2'd3}; CMD_VALID = 1'b1;
      tick(); CMD_VALID = 1'b0;
      chk1("ill.done", DONE, 1'b1);
      chk1("ill.busy", BUSY, 1'b1);
      chk1("ill.err_early", ERR, 1'b0);
      chk1("ill.addr_inc", ADDR_INC, 1'b0);
      chk1("ill.bars", &{ADDR_ASSERT_bar, ADDR_LOAD_bar, MAIN_ASSERT_bar, MAIN_LOAD_bar,
                         LHS_ASSERT_bar, RHS_ASSERT_bar, MEM_READ_bar, ALU_ASSERT_bar}, 1'b1);
      tick();
      chk1("ill.err_set", ERR, 1'b1);
      chk1("ill.busy_after", BUSY, 1'b0);
      tick(); tick(); tick();
      chk1("ill.err_hold", ERR, 1'b1);
      CMD = {3'd0, 2'd1, 2'd2, 2'd0}; CMD_VALID = 1'b1;
      tick(); CMD_VALID = 1'b0;
      chk1("ill.err_after_mov", ERR, 1'b1);
      tick();

      // Reset during FETCH EX1
      CMD = {3'd2, 2'd1, 2'd3, 2'd0}; CMD_VALID = 1'b1;
      tick(); CMD_VALID = 1'b0;
      chk1("rstf.mem_read", MEM_READ_bar, 1'b0);
      RST_bar = 1'b0;
      tick();
      check_idle("rstf");
      chk1("rstf.err", ERR, 1'b0);
      RST_bar = 1'b1;
      tick();
      check_idle("rstf_release");

      // Random stream: at most one MAIN-bus driver per cycle
      for (int i = 0; i < 300; i++) begin
         int drv;
         CMD       = 9'($urandom_range(0, 511));
         CMD_VALID = 1'($urandom_range(0, 1));
         tick();
         drv = int'(!MAIN_ASSERT_bar) + int'(!MEM_READ_bar) + int'(!ALU_ASSERT_bar);
         chk1("rand.main_bus_excl", (drv <= 1), 1'b1);
      end
      CMD_VALID = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
